mcp_ctrl: RTL
=============

Name: mcp_ctrl

Overview:
- Multicycle main controller: a Moore/Mealy FSM that sequences the shared-ALU, unified-memory MIPS datapath one instruction phase per cycle.
- Replaces the single-cycle combinational decoder when the datapath is rebuilt around IR/MDR/A/B/ALUOut registers.
- Inputs are the IR opcode and a memory ready handshake. Outputs drive every datapath mux select, register enable and memory strobe.

Parameters:
- TIMEOUT, 16: max cycles to wait for mem_ready in a memory state. 0 disables the watchdog.
- STATE_W, 4: width of the state register and of the state port.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- opcode  input  6  IR[31:26], stable from DECODE until the next FETCH
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if branch condition is true
- beq  output  1  branch polarity: 1 = taken on zero, 0 = taken on ~zero (bne)
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load enable
- mem_to_reg  output  1  register write data: 0 = ALUOut, 1 = MDR
- reg_dst  output  1  destination register: 0 = rt, 1 = rd
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = A
- alu_src_b  output  2  ALU B input: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
- alu_op  output  2  00 = add, 01 = sub, 10 = funct, 11 = and
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump address
- state  output  STATE_W  current state, for debug
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_err  output  1  one-cycle pulse on watchdog expiry

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12-15 are illegal; any illegal state goes to FETCH.
- Reset: state <= FETCH and the watchdog counter clears. While reset is high, all outputs are forced to 0.
- Reset asserted mid-instruction aborts it. There are no writes in the reset cycle, and FETCH is the first state after reset deasserts.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100/000101 -> BRANCH; 000010 -> JUMP; 001000/001100 -> IEXEC.
  - Any other opcode -> FETCH, with illegal_op=1 and instr_done=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready. instr_done=mem_ready. Then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - beq = 1 for opcode 000100 and 0 for 000101.
  - Next state FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_op=00 for addi and 11 for andi. Next state IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- Outputs not listed for a state are 0.
- beq is held at 1 outside BRANCH, so it is don't-care there.
- Latency with mem_ready tied high:
  - j and beq/bne: 3 cycles.
  - R-type, sw, addi/andi: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Watchdog (TIMEOUT>0):
  - A counter increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0. It clears on any state change.
  - When the counter reaches TIMEOUT-1 and mem_ready=0: mem_err=1 for that cycle and next state is FETCH.
  - No ir_write, pc_write, reg_write or mem_write is issued for the aborted access.
  - If mem_ready and expiry coincide, mem_ready wins (normal completion, no mem_err).

Optional Feature:
- Macro: MCP_PERF_EN.
- When defined:
  - Adds output ports cycle_cnt[31:0] and instr_cnt[31:0].
  - Both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each instr_done pulse.
  - Both wrap 0xFFFFFFFF -> 0.
- When undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 and opcode=100011 -> state sequence 0,1,2,3,4,0. reg_write and mem_to_reg are 1 only in state 4; instr_done pulses in cycle 5.
- R-type (opcode 0) then beq (000100) back-to-back, mem_ready=1 -> states 0,1,6,7,0,1,8,0. In state 8: pc_write_cond=1, beq=1, alu_op=01, pc_source=01.
- sw (101011) with mem_ready low 3 cycles in MEMWR -> state 5 holds 4 cycles with mem_write=1 throughout. instr_done pulses only in the mem_ready cycle.
- opcode 111111 -> DECODE pulses illegal_op=1 and instr_done=1; next state 0; no reg_write/mem_write at any point.
- TIMEOUT=4, mem_ready=0 in FETCH -> mem_err pulses in the 4th FETCH cycle, state re-enters FETCH, ir_write never 1. Raising mem_ready on the 4th cycle instead -> DECODE, no mem_err.
- With MCP_PERF_EN: reset, then two j instructions (000010) -> after 6 cycles cycle_cnt=6, instr_cnt=2. Reset asserted in state 9 -> both counters 0 the next cycle and state=0.

Source files
------------

// File: rtl/mcp_ctrl.sv
// Multicycle MIPS main controller: phase FSM with memory-handshake watchdog.
// Optional MCP_PERF_EN adds free-running cycle/instruction counters.
module mcp_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               beq,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_err
`ifdef MCP_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWR  = 4'd5, S_EXEC   = 4'd6, S_RWB   = 4'd7,
    S_BRANCH = 4'd8, S_JUMP  = 4'd9, S_IEXEC  = 4'd10, S_IWB  = 4'd11
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             w_wait;
  logic             w_expire;

  assign w_wait   = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                    && !mem_ready;
  // Ready on the expiry cycle counts as completion, so only a stalled cycle can expire.
  assign w_expire = (TIMEOUT > 0) && w_wait && (r_wd_cnt == WD_LAST);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = (mem_ready || w_expire) ? (mem_ready ? S_DECODE : S_FETCH) : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'h00:        w_next = S_EXEC;
          6'h23, 6'h2B: w_next = S_MEMADR;
          6'h04, 6'h05: w_next = S_BRANCH;
          6'h02:        w_next = S_JUMP;
          6'h08, 6'h0C: w_next = S_IEXEC;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : (w_expire ? S_FETCH : S_MEMRD);
      S_MEMWR:  w_next = (mem_ready || w_expire) ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_RWB;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_wd_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_expire) r_wd_cnt <= '0;
      else if (w_wait)                     r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  always_comb begin
    pc_write = 1'b0; pc_write_cond = 1'b0; beq = 1'b1; i_or_d = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; mem_to_reg = 1'b0;
    reg_dst = 1'b0; reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00;
    alu_op = 2'b00; pc_source = 2'b00; instr_done = 1'b0; illegal_op = 1'b0;
    mem_err = 1'b0;
    state = STATE_W'(r_state);
    case (r_state)
      S_FETCH: begin
        mem_read = 1'b1; alu_src_b = 2'b01;
        ir_write = mem_ready; pc_write = mem_ready; mem_err = w_expire;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (w_next == S_FETCH) begin
          illegal_op = 1'b1; instr_done = 1'b1;
        end
      end
      S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:  begin mem_read = 1'b1; i_or_d = 1'b1; mem_err = w_expire; end
      S_MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; instr_done = 1'b1; end
      S_MEMWR: begin
        // Strobe is withdrawn on the expiry cycle so the abandoned store never lands.
        mem_write = !w_expire; i_or_d = 1'b1; instr_done = mem_ready; mem_err = w_expire;
      end
      S_EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_RWB:    begin reg_write = 1'b1; reg_dst = 1'b1; instr_done = 1'b1; end
      S_BRANCH: begin
        alu_src_a = 1'b1; alu_op = 2'b01; pc_write_cond = 1'b1; pc_source = 2'b01;
        instr_done = 1'b1; beq = (opcode == 6'h04);
      end
      S_JUMP:   begin pc_write = 1'b1; pc_source = 2'b10; instr_done = 1'b1; end
      S_IEXEC:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = (opcode == 6'h0C) ? 2'b11 : 2'b00; end
      S_IWB:    begin reg_write = 1'b1; instr_done = 1'b1; end
      default: ;
    endcase
    if (reset) begin
      pc_write = 1'b0; pc_write_cond = 1'b0; beq = 1'b0; i_or_d = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; mem_to_reg = 1'b0;
      reg_dst = 1'b0; reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00;
      alu_op = 2'b00; pc_source = 2'b00; instr_done = 1'b0; illegal_op = 1'b0;
      mem_err = 1'b0; state = '0;
    end
  end

`ifdef MCP_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule
